// File: rtl/uart_mem_dump.sv
// Streams a RAM block out of an 8N1 UART as: sync, length hi/lo, data bytes, checksum.
// RAM access is requested from the shared-RAM arbiter, and a lost grant replays the read in progress.
module uart_mem_dump #(
  parameter int          CLK_HZ     = 25000000,
  parameter int          BAUD       = 57600,
  parameter int          ADDR_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [15:0]           i_length,
  output logic                  o_ask_for_ram,
  input  logic                  i_ram_granted,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [7:0]            i_rdata,
  output logic                  o_serial_txd,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_REQ, S_FETCH, S_WAIT_DATA, S_SEND, S_CHK, S_FINISH
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [15:0]           r_len;
  logic [7:0]            r_sum;
  logic [7:0]            r_buf;
  logic [1:0]            r_hdr_idx;
  logic                  r_wait;
  logic                  r_ask;
  logic                  r_busy;
  logic                  r_done;

  logic                  r_tx_busy;
  logic [CNT_W-1:0]      r_tx_cnt;
  logic [3:0]            r_tx_bit;
  logic [8:0]            r_tx_shift;
  logic                  r_txd;

  logic                  w_tx_end;
  logic                  w_tx_ready;
  logic                  w_tx_load;
  logic [7:0]            w_tx_byte;

  // The last clock of a stop bit counts as ready so the next start bit follows with no gap.
  assign w_tx_end   = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == CNT_LAST);
  assign w_tx_ready = !r_tx_busy || w_tx_end;

  always_comb begin
    w_tx_load = 1'b0;
    w_tx_byte = 8'h00;
    case (r_state)
      S_HDR: begin
        w_tx_load = w_tx_ready;
        case (r_hdr_idx)
          2'd0:    w_tx_byte = SYNC_BYTE;
          2'd1:    w_tx_byte = r_len[15:8];
          default: w_tx_byte = r_len[7:0];
        endcase
      end
      S_SEND: begin
        w_tx_load = w_tx_ready;
        w_tx_byte = r_buf;
      end
      S_CHK: begin
        w_tx_load = w_tx_ready;
        w_tx_byte = r_sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 4'd0;
      r_tx_shift <= '1;
      r_txd      <= 1'b1;
    end else if (w_tx_load) begin
      r_tx_busy  <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 4'd0;
      r_tx_shift <= {1'b1, w_tx_byte};
      r_txd      <= 1'b0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == CNT_LAST) begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_txd     <= 1'b1;
        end else begin
          r_tx_bit   <= r_tx_bit + 4'd1;
          r_txd      <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_raddr   <= '0;
      r_len     <= 16'd0;
      r_sum     <= 8'h00;
      r_buf     <= 8'h00;
      r_hdr_idx <= 2'd0;
      r_wait    <= 1'b0;
      r_ask     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr    <= i_start_addr;
            r_len     <= i_length;
            r_sum     <= 8'h00;
            r_hdr_idx <= 2'd0;
            r_busy    <= 1'b1;
            r_state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_tx_ready) begin
            if (r_hdr_idx == 2'd2) begin
              r_hdr_idx <= 2'd0;
              if (r_len == 16'd0) begin
                r_state <= S_CHK;
              end else begin
                r_ask   <= 1'b1;
                r_state <= S_REQ;
              end
            end else begin
              r_hdr_idx <= r_hdr_idx + 2'd1;
            end
          end
        end
        S_REQ: begin
          r_ask <= 1'b1;
          if (i_ram_granted) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (!i_ram_granted) begin
            r_state <= S_REQ;
          end else begin
            r_raddr <= r_addr;
            r_wait  <= 1'b0;
            r_state <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          // rdata is valid on the second edge after raddr moves; a dropped grant voids it.
          if (!i_ram_granted) begin
            r_state <= S_REQ;
          end else if (!r_wait) begin
            r_wait <= 1'b1;
          end else begin
            r_buf <= i_rdata;
            r_sum <= r_sum + i_rdata;
            if (r_len == 16'd1) r_ask <= 1'b0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_tx_ready) begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_len   <= r_len - 16'd1;
            r_state <= (r_len == 16'd1) ? S_CHK : S_FETCH;
          end
        end
        S_CHK: begin
          if (w_tx_ready) r_state <= S_FINISH;
        end
        S_FINISH: begin
          if (w_tx_end) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ask_for_ram = r_ask;
  assign o_raddr       = r_raddr;
  assign o_serial_txd  = r_txd;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench: tasks queue the expected frame bytes, a serial monitor decodes the line and scores them.
module tb_uart_mem_dump;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = 16'h0;
  logic [15:0] length = 16'h0;
  logic        ask;
  logic        granted = 1'b1;
  logic [15:0] raddr;
  logic [7:0]  rdata;
  logic        txd;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0]  ram [0:65535];
  logic [7:0]  exp_q[$];
  logic [15:0] raddr_log[$];
  logic [15:0] prev_raddr = 16'h0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_start = 0;
  int byte_cnt = 0;
  bit ask_seen = 0;
  bit spacing_on = 0;
  bit prev_done = 0;

  bit       m_active = 0;
  int       m_cnt = 0;
  logic [7:0] m_byte;

  always #5 clk = ~clk;

  uart_mem_dump #(.CLK_HZ(16), .BAUD(1), .ADDR_WIDTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(start), .i_start_addr(start_addr),
    .i_length(length), .o_ask_for_ram(ask), .i_ram_granted(granted), .o_raddr(raddr),
    .i_rdata(rdata), .o_serial_txd(txd), .o_busy(busy), .o_done(done)
  );

  always @(posedge clk) rdata <= ram[raddr];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle-based serial decoder; samples the middle of each 16-clock bit.
  always @(negedge clk) begin
    cyc++;
    if (ask) ask_seen = 1;
    if (raddr !== prev_raddr) begin
      raddr_log.push_back(raddr);
      prev_raddr = raddr;
    end
    if (done) begin
      if (prev_done) check("done_single_cycle", 1, 0);
      done_cnt++;
      done_cyc = cyc;
      if (spacing_on) check("done_after_last_stop", cyc - last_start, 160);
    end
    prev_done = done;
    if (!reset_n) begin
      m_active = 0;
    end else if (!m_active) begin
      if (txd === 1'b0) begin
        m_active = 1;
        m_cnt = 0;
        if (spacing_on && byte_cnt > 0) check("frame_spacing", cyc - last_start, 160);
        last_start = cyc;
        byte_cnt++;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 7) check("start_bit", txd, 0);
      for (int i = 0; i < 8; i++)
        if (m_cnt == 7 + 16 * (i + 1)) m_byte[i] = txd;
      if (m_cnt == 151) begin
        check("stop_bit", txd, 1);
        check("busy_in_frame", busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", m_byte, 9'h100);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          $display("[TB] rx byte 0x%02h expected 0x%02h", m_byte, e);
          check("rx_byte", m_byte, e);
        end
        m_active = 0;
      end
    end
  end

  task automatic push_frame(input logic [15:0] addr, input logic [15:0] len);
    logic [7:0] s;
    logic [15:0] a;
    s = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 16'(i);
      s = s + ram[a];
      exp_q.push_back(ram[a]);
    end
    exp_q.push_back(s);
  endtask

  task automatic pulse_start(input logic [15:0] addr, input logic [15:0] len);
    @(negedge clk);
    start = 1'b1;
    start_addr = addr;
    length = len;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string name);
    int base;
    int t;
    base = done_cnt;
    t = 0;
    while (done_cnt == base && t < 6000) begin
      @(posedge clk);
      t++;
    end
    check({name, "_done_seen"}, int'(done_cnt != base), 1);
    repeat (20) @(posedge clk);
    check({name, "_done_count"}, done_cnt - base, 1);
    check({name, "_all_bytes"}, exp_q.size(), 0);
    check({name, "_busy_low"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7 + 3);
    ram[16'h0200] = 8'h01; ram[16'h0201] = 8'h02; ram[16'h0202] = 8'h03;
    ram[16'hFFFE] = 8'h10; ram[16'hFFFF] = 8'h20; ram[16'h0000] = 8'h30;
    ram[16'h0300] = 8'h11; ram[16'h0301] = 8'h22; ram[16'h0302] = 8'h33; ram[16'h0303] = 8'h44;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ask", ask, 0);
    check("rst_raddr", raddr, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: basic dump, A5 00 03 01 02 03 06, back-to-back frames
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h03);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    exp_q.push_back(8'h06);
    spacing_on = 1; byte_cnt = 0;
    pulse_start(16'h0200, 16'd3);
    wait_done("basic");
    check("basic_byte_count", byte_cnt, 7);
    spacing_on = 0;

    // 2: zero length, no RAM request
    ask_seen = 0;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    pulse_start(16'h1234, 16'd0);
    wait_done("len0");
    check("len0_no_ask", ask_seen, 0);

    // 3: address wrap, checksum 0x60
    raddr_log.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h03);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h30);
    exp_q.push_back(8'h60);
    pulse_start(16'hFFFE, 16'd3);
    wait_done("wrap");
    check("wrap_raddr_n", raddr_log.size(), 3);
    if (raddr_log.size() == 3) begin
      check("wrap_raddr0", raddr_log[0], 16'hFFFE);
      check("wrap_raddr1", raddr_log[1], 16'hFFFF);
      check("wrap_raddr2", raddr_log[2], 16'h0000);
    end

    // 4: grant dropped for 50 cycles during the second data fetch
    begin
      int t;
      bit ask_dropped;
      bit raddr_moved;
      ask_dropped = 0; raddr_moved = 0;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h04);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      exp_q.push_back(8'h44); exp_q.push_back(8'hAA);
      pulse_start(16'h0300, 16'd4);
      t = 0;
      while (raddr !== 16'h0301 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("grant_second_fetch_seen", raddr, 16'h0301);
      granted = 1'b0;
      repeat (50) begin
        @(negedge clk);
        if (!ask) ask_dropped = 1;
        if (raddr !== 16'h0301) raddr_moved = 1;
      end
      granted = 1'b1;
      wait_done("grant");
      check("grant_ask_held", ask_dropped, 0);
      check("grant_raddr_held", raddr_moved, 0);
    end

    // 5: second start mid-dump is ignored
    push_frame(16'h0200, 16'd3);
    pulse_start(16'h0200, 16'd3);
    repeat (300) @(negedge clk);
    pulse_start(16'h4000, 16'd9);
    wait_done("restart_ignored");

    // 6: reset during a data bit, then a clean frame
    push_frame(16'h0300, 16'd3);
    pulse_start(16'h0300, 16'd3);
    repeat (530) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_txd", txd, 1);
    check("abort_busy", busy, 0);
    check("abort_ask", ask, 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_line_idle", txd, 1);
    push_frame(16'h0300, 16'd3);
    pulse_start(16'h0300, 16'd3);
    wait_done("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_mem_dump.md
Name: uart_mem_dump

Overview:
UART transmitter that streams a block of system RAM back to the host. It is the return path of the UART program loader. On a start pulse it requests the shared RAM, reads `length` bytes from `start_addr`, and sends them framed on `serial_txd` as 8N1. The CPU/VGA arbitration in the top level grants RAM access via `ram_granted`, the same way it does for the loader.

Parameters:
CLK_HZ, 25000000, clock frequency in Hz
BAUD, 57600, line rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated (434 at defaults)
ADDR_WIDTH, 16, RAM address width
SYNC_BYTE, 8'hA5, frame header byte

Ports:
clk  in  1  system clock (25 MHz domain, same as RAM)
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a dump; ignored while busy
start_addr  in  ADDR_WIDTH  first address; sampled on accepted start
length  in  16  byte count; sampled on accepted start
ask_for_ram  out  1  request RAM ownership from arbiter
ram_granted  in  1  arbiter grant; RAM port may be driven only while high
raddr  out  ADDR_WIDTH  registered RAM read address
rdata  in  8  RAM read data; synchronous RAM, one-cycle read latency
serial_txd  out  1  UART output, idle high
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when stop bit of last frame byte ends

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous and active-low.
  - All outputs are asserted asynchronously on reset: serial_txd=1, busy=0, done=0, ask_for_ram=0, raddr=0.
  - Reset mid-frame aborts immediately. No partial stop bit is generated; the line returns high at once.
- Frame order, all bytes LSB-first, 8N1:
  - SYNC_BYTE
  - length[15:8]
  - length[7:0]
  - data bytes
  - checksum = 8-bit modular sum of the data bytes (0x00 if length=0)
- Byte transmitter:
  - One start bit (0), 8 data bits, one stop bit (1). Each bit lasts exactly CLKS_PER_BIT clocks.
  - Next byte's start bit follows the stop bit with no gap when that byte is ready. Otherwise the line idles high.
  - Tx accepts a byte only when idle. Load-to-start-bit latency is 1 clock.
- Control FSM states: IDLE, HDR, REQ, FETCH, WAIT_DATA, SEND, CHK, FINISH.
  - IDLE: when start=1, latch addr/len, clear checksum, busy<=1 next cycle, go to HDR.
  - HDR: send the three header bytes. If len=0, go to CHK. Otherwise go to REQ.
  - REQ: assert ask_for_ram; wait for ram_granted=1, then go to FETCH.
  - FETCH: drive raddr=addr. The sequence is:
    1. Drive raddr=addr.
    2. Go to WAIT_DATA.
    3. Sample rdata on the second rising edge after raddr updates.
    4. Add it to the checksum.
    5. Go to SEND.
  - SEND: hand the byte to Tx once idle. Then addr+1, wrapping 0xFFFF→0x0000 at ADDR_WIDTH, and len-1. If len is now 0, go to CHK; otherwise go to FETCH.
  - CHK: send the checksum byte, then go to FINISH.
  - FINISH: after the checksum stop bit completes, pulse done for 1 cycle, drop busy, return to IDLE.
- ask_for_ram:
  - Asserted from REQ until the last data byte has been sampled. Not asserted at all when len=0.
- Grant loss:
  - If ram_granted falls during FETCH/WAIT_DATA, discard that read and return to REQ with the same addr.
  - Do not retry until the grant is seen again. No byte is duplicated or skipped.
- Prefetch:
  - The next byte may be fetched while the previous one is still shifting out. At most one byte is buffered.
- start during busy:
  - Ignored; the latched addr/len are unaffected.

Test Plan:
1. Params CLK_HZ=16, BAUD=1 (16 clk/bit); start, addr=0x0200, len=3, RAM[0x200..0x202]=01,02,03 → serial decodes A5 00 03 01 02 03 06. Each bit is 16 clocks; busy high throughout; a single done pulse follows the final stop bit.
2. len=0 → bytes A5 00 00 00; ask_for_ram never asserted; done pulses.
3. addr=0xFFFE, len=3, RAM[FFFE]=10, [FFFF]=20, [0000]=30 → raddr sequence FFFE, FFFF, 0000; checksum 0x60.
4. ram_granted dropped for 50 cycles during the second data fetch of len=4 → the full byte stream is intact; raddr re-issued at the same address; ask_for_ram held high.
5. Second start pulse mid-dump with different addr/len → ignored; output identical to the undisturbed run.
6. reset_n low during a data bit → serial_txd=1, busy=0, ask_for_ram=0 within the same cycle. A new start after release produces a clean full frame.
